// File: rtl/dadda_dot_pkg.sv
// Shared definitions for the dadda_dot_accum dot-product engine.
//   state_e   : controller states (IDLE, RUN, DRAIN, DONE)
//   MUL_W     : multiplier operand width
//   PROD_W    : multiplier product width
//   acc_w_ok  : true when an accumulator of acc_w bits can hold the sum of
//               up to 2^len_w-1 full-scale products without overflow
package dadda_dot_pkg;

  localparam int MUL_W  = 16;
  localparam int PROD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic bit acc_w_ok(input int acc_w, input int len_w);
    return acc_w >= PROD_W + len_w;
  endfunction

endpackage

// File: rtl/dadda_dot_pipe.sv
// Register stages around the external combinational multiplier.
//   Stage 1: operand registers driving the multiplier inputs (mul_a_o/mul_b_o)
//            plus a valid bit; operands hold when nothing is loaded.
//   Stage 2: product register capturing mul_p_i plus a valid bit.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   load_i         an accepted operand pair is presented on a_i/b_i
//   a_i, b_i       operands to load into stage 1
//   mul_p_i        multiplier product for the stage-1 operands
//   mul_a_o/b_o    stage-1 operand registers
//   prod_o         stage-2 product register
//   prod_valid_o   stage-2 holds a product that must be accumulated
//   pipe_empty_o   stage 1 holds no operand pair, so nothing is behind stage 2
module dadda_dot_pipe
  import dadda_dot_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [MUL_W-1:0]  a_i,
  input  logic [MUL_W-1:0]  b_i,
  input  logic [PROD_W-1:0] mul_p_i,
  output logic [MUL_W-1:0]  mul_a_o,
  output logic [MUL_W-1:0]  mul_b_o,
  output logic [PROD_W-1:0] prod_o,
  output logic              prod_valid_o,
  output logic              pipe_empty_o
);

  logic [MUL_W-1:0]  a_q, a_d, b_q, b_d;
  logic              s1_v_q, s1_v_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic              s2_v_q, s2_v_d;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    prod_d = prod_q;
    if (load_i) begin
      a_d = a_i;
      b_d = b_i;
    end
    s1_v_d = load_i;
    // Only capture mul_p when it belongs to a real stage-1 pair, so a stale
    // product can never be tagged valid.
    if (s1_v_q) begin
      prod_d = mul_p_i;
    end
    s2_v_d = s1_v_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      s1_v_q <= 1'b0;
      prod_q <= '0;
      s2_v_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      s1_v_q <= s1_v_d;
      prod_q <= prod_d;
      s2_v_q <= s2_v_d;
    end
  end

  assign mul_a_o      = a_q;
  assign mul_b_o      = b_q;
  assign prod_o       = prod_q;
  assign prod_valid_o = s2_v_q;
  assign pipe_empty_o = ~s1_v_q;

endmodule

// File: rtl/dadda_dot_accum.sv
// Sequential dot-product engine around an external 16x16 unsigned multiplier.
// Accepts len operand pairs, multiplies them through registered mul_a/mul_b ->
// mul_p -> product register, and accumulates the products into out_acc.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. in_ready depends only on registered state; out_valid stays high and
// out_acc/out_count stay stable until out_ready is seen.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, len          begin a dot product of len terms (only taken in IDLE)
//   in_valid/in_ready   operand pair handshake, operands on in_a/in_b
//   mul_a, mul_b        registered operands to the multiplier
//   mul_p               multiplier product
//   out_valid/out_ready result handshake, result on out_acc/out_count
//   busy                controller is not in IDLE
//   stall_cycles        RUN cycles waiting on in_valid
// Optional feature macro: DADDA_DOT_STALL_CNT_EN enables the stall counter;
// without it stall_cycles is constant zero.
module dadda_dot_accum
  import dadda_dot_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MUL_W-1:0]  in_a,
  input  logic [MUL_W-1:0]  in_b,
  output logic [MUL_W-1:0]  mul_a,
  output logic [MUL_W-1:0]  mul_b,
  input  logic [PROD_W-1:0] mul_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [LEN_W-1:0]  out_count,
  output logic              busy,
  output logic [15:0]       stall_cycles
);

  if (!acc_w_ok(ACC_W, LEN_W)) begin : g_acc_w_too_small
    $error("dadda_dot_accum: ACC_W must be at least 32+LEN_W");
  end

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               in_ready_c;
  logic               out_valid_c;
  logic               accept;
  logic [PROD_W-1:0]  prod;
  logic               prod_valid;
  logic               pipe_empty;

  dadda_dot_pipe u_pipe (
    .clk          (clk),
    .rst          (rst),
    .load_i       (accept),
    .a_i          (in_a),
    .b_i          (in_b),
    .mul_p_i      (mul_p),
    .mul_a_o      (mul_a),
    .mul_b_o      (mul_b),
    .prod_o       (prod),
    .prod_valid_o (prod_valid),
    .pipe_empty_o (pipe_empty)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    acc_d       = acc_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    accept      = 1'b0;

    // The pipe is empty in IDLE, so this never collides with the clear below.
    if (prod_valid) begin
      acc_d = acc_q + ACC_W'(prod);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          count_d = '0;
          acc_d   = '0;
          state_d = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        in_ready_c = (count_q < len_q);
        accept     = in_valid && in_ready_c;
        if (accept) begin
          count_d = count_q + LEN_W'(1);
          if (count_d == len_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Last product sits in stage 2 with nothing behind it: it is added at
        // this edge, so the sum is complete when DONE is entered.
        if (pipe_empty && prod_valid) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      count_q <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_c;
  assign out_acc   = acc_q;
  assign out_count = count_q;
  assign busy      = (state_q != IDLE);

`ifdef DADDA_DOT_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start) begin
      stall_d = '0;
    end else if (state_q == RUN && in_ready_c && !in_valid &&
                 stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
